// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential RV32M divide unit.
//   - XLEN      : operand/result width (32 only)
//   - DIV_ITERS : restoring-divide iterations, one quotient bit per cycle
//   - LATENCY   : cycles from request accept to first resp_valid
//   - div_op_e  : RV32M divide opcode as carried on req_op
//   - div_state_e : controller state
package div_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;
  localparam int LATENCY   = 37;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEG_A = 3'd1,
    S_NEG_B = 3'd2,
    S_DIV   = 3'd3,
    S_NEG_Q = 3'd4,
    S_NEG_R = 3'd5,
    S_DONE  = 3'd6
  } div_state_e;

endpackage

// File: rtl/twos_negate.sv
// twos_negate: combinational two's-complement negation (~x + 1).
//   x : value to negate
//   y : -x modulo 2^XLEN
module twos_negate #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] x,
  output logic [XLEN-1:0] y
);

  assign y = ~x + XLEN'(1);

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle RV32M divider (DIV/DIVU/REM/REMU).
// Strips operand signs, runs a 32-step restoring divide and fixes the result
// sign, all through one shared negator selected by the current state.
//   clk, rst_n  : clock, async active-low reset
//   flush       : synchronous abort of any in-flight op (wins over everything)
//   req_valid/req_ready, req_op, req_a, req_b : request channel
//   resp_valid/resp_ready, resp_data          : response channel
//   busy        : unit is not idle
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is high only in IDLE without flush. Once resp_valid
// rises, resp_valid and resp_data hold until the edge where resp_ready is
// high (or a flush/reset); resp_data reads zero whenever resp_valid is low.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int XLEN  = div_pkg::XLEN,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  div_state_e        state;
  logic              op_rem;   // remainder wanted rather than quotient
  logic              sa, sb;   // operand was negative (signed ops only)
  logic              dz;       // divide by zero
  logic [XLEN-1:0]   a_orig;
  logic [XLEN-1:0]   b_reg;
  logic [XLEN-1:0]   dvd;      // |a|, shifting left; quotient bits fill from the bottom
  logic [XLEN-1:0]   bmag;     // |b|
  logic [XLEN-1:0]   rem;
  logic [CNT_W-1:0]  cnt;

  logic [XLEN-1:0]   neg_in, neg_out;
  logic [XLEN:0]     rem_sh, trial;
  logic [XLEN-1:0]   rem_fix, result;

  // Single negator: operand stripping, then quotient and remainder fixup.
  always_comb begin
    neg_in = '0;
    case (state)
      S_NEG_A: neg_in = a_orig;
      S_NEG_B: neg_in = b_reg;
      S_NEG_Q: neg_in = dvd;
      S_NEG_R: neg_in = rem;
      default: neg_in = '0;
    endcase
  end

  twos_negate #(.XLEN(XLEN)) u_neg (
    .x (neg_in),
    .y (neg_out)
  );

  // Restoring step: bring in the next dividend bit, try subtracting |b|.
  // trial[XLEN] set means the subtraction went negative (quotient bit 0).
  assign rem_sh = {rem, dvd[XLEN-1]};
  assign trial  = rem_sh - {1'b0, bmag};

  // Divide-by-zero overrides; 0x80000000 / -1 needs none.
  assign rem_fix = sa ? neg_out : rem;
  always_comb begin
    result = '0;
    if (op_rem) result = dz ? a_orig : rem_fix;
    else        result = dz ? '1 : dvd;
  end

  assign req_ready = (state == S_IDLE) && !flush;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_rem     <= 1'b0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      dz         <= 1'b0;
      a_orig     <= '0;
      b_reg      <= '0;
      dvd        <= '0;
      bmag       <= '0;
      rem        <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (flush) begin
      state      <= S_IDLE;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_orig <= req_a;
            b_reg  <= req_b;
            op_rem <= req_op[1];
            sa     <= req_a[XLEN-1] & ~req_op[0];
            sb     <= req_b[XLEN-1] & ~req_op[0];
            dz     <= (req_b == '0);
            rem    <= '0;
            cnt    <= '0;
            state  <= S_NEG_A;
          end
        end
        S_NEG_A: begin
          dvd   <= sa ? neg_out : a_orig;
          state <= S_NEG_B;
        end
        S_NEG_B: begin
          bmag  <= sb ? neg_out : b_reg;
          state <= S_DIV;
        end
        S_DIV: begin
          rem <= trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
          dvd <= {dvd[XLEN-2:0], ~trial[XLEN]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIV_ITERS - 1)) state <= S_NEG_Q;
        end
        S_NEG_Q: begin
          if (sa ^ sb) dvd <= neg_out;
          state <= S_NEG_R;
        end
        S_NEG_R: begin
          resp_data  <= result;
          resp_valid <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed and randomized checks of div_seq_ctrl against an
// arithmetic model of the RV32M divide semantics.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  div_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_model(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int signed ai, bi;
    ai = a;
    bi = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ai / bi);
      end
      2'b01: return a / b;
      2'b10: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ai % bi);
      end
      default: return a % b;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- comparison ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a request at a falling edge; it is accepted on the next rising edge.
  task automatic send_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait for resp_valid; returns the count of falling edges after accept.
  task automatic wait_resp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 60);
  endtask

  // One full operation; hold = cycles resp_ready stays low in DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    int cyc;
    exp_q.push_back(ref_model(op, a, b));
    resp_ready = 1'b0;
    send_req(op, a, b);
    resp_ready = (hold == 0);
    wait_resp(cyc);
    exp = exp_q.pop_front();
    check("latency", 32'(cyc), 32'd37);
    check("resp_data", resp_data, exp);
    check("req_ready_in_done", {31'b0, req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("held_valid", {31'b0, resp_valid}, 32'd1);
      check("held_data", resp_data, exp);
      check("held_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("post_valid", {31'b0, resp_valid}, 32'd0);
    check("post_data", resp_data, 32'h0);
    check("post_req_ready", {31'b0, req_ready}, 32'd1);
    check("post_busy", {31'b0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst_n      = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Directed operations.
    run_op(2'b00, 32'd20, 32'hFFFF_FFFD, 0);
    run_op(2'b10, 32'd20, 32'hFFFF_FFFD, 0);
    run_op(2'b10, 32'hFFFF_FFEC, 32'd3, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(2'b00, 32'd7, 32'd0, 0);
    run_op(2'b10, 32'd7, 32'd0, 0);
    run_op(2'b11, 32'h8000_0000, 32'd0, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b01, 32'h8000_0000, 32'd0, 0);
    run_op(2'b00, 32'd100, 32'd7, 5);

    // Flush during the divide.
    resp_ready = 1'b1;
    send_req(2'b00, 32'd12345, 32'd67);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_valid", {31'b0, resp_valid}, 32'd0);
    check("flush_req_ready", {31'b0, req_ready}, 32'd1);

    // Flush with a request pending in IDLE: not accepted.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_a     = 32'd9;
    req_b     = 32'd3;
    #1;
    check("flush_idle_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (resp_valid || busy) seen++;
    end
    check("flush_no_resp", 32'(seen), 32'd0);

    // Flush while holding a result in DONE.
    resp_ready = 1'b0;
    send_req(2'b01, 32'd50, 32'd5);
    wait_resp(cyc);
    check("done_latency", 32'(cyc), 32'd37);
    check("done_data", resp_data, 32'd10);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("done_flush_valid", {31'b0, resp_valid}, 32'd0);
    check("done_flush_data", resp_data, 32'h0);
    check("done_flush_busy", {31'b0, busy}, 32'd0);
    resp_ready = 1'b1;

    // Reset pulse mid-op.
    send_req(2'b00, 32'd999, 32'd4);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_valid", {31'b0, resp_valid}, 32'd0);
    check("midrst_data", resp_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    run_op(2'b10, 32'd999, 32'd4, 0);

    // Randomized operations.
    for (int n = 0; n < 20; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = rand_operand();
      rb  = rand_operand();
      run_op(rop, ra, rb, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
